// File: rtl/iq_issue_arbiter_pkg.sv
// iq_issue_arbiter_pkg: shared core constants (FU encodings, queue/ROB/register sizing)
package iq_issue_arbiter_pkg;
    localparam int NUM_FU        = 4;
    localparam int FU_W          = 2;
    localparam int IQ_SIZE_DEF   = 16;
    localparam int ROB_SIZE_LOG2 = 6;
    localparam int REG_SIZE      = 64;

    typedef enum logic [FU_W-1:0] {
        FU_ALU = 2'd0,
        FU_LSU = 2'd1,
        FU_MUL = 2'd2,
        FU_BR  = 2'd3
    } fu_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IQ_IDX_W = idx_w(IQ_SIZE_DEF);
endpackage

// File: rtl/iq_issue_arbiter_rr_pick.sv
// iq_issue_arbiter_rr_pick: circular first-one finder starting at i_start
module iq_issue_arbiter_rr_pick #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic [N-1:0] i_mask,
    input  logic [W-1:0] i_start,
    output logic         o_found,
    output logic [W-1:0] o_idx
);
    // Walk from the far end back to i_start so the closest hit wins.
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_mask[W'((int'(i_start) + k) % N)]) begin
                o_found = 1'b1;
                o_idx   = W'((int'(i_start) + k) % N);
            end
        end
    end
endmodule

// File: rtl/iq_issue_arbiter.sv
// iq_issue_arbiter: multi-port round-robin issue selection with one grant per FU
// and hold-until-fire grant registers.
module iq_issue_arbiter
    import iq_issue_arbiter_pkg::*;
#(
    parameter int IQ_SIZE     = iq_issue_arbiter_pkg::IQ_SIZE_DEF,
    parameter int ISSUE_PORTS = 2,
    parameter int NUM_FU      = iq_issue_arbiter_pkg::NUM_FU,
    localparam int IW         = idx_w(IQ_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        stall_in,
    input  logic                        flush,
    input  logic [IQ_SIZE-1:0]          entry_valid,
    input  logic [IQ_SIZE-1:0]          entry_ready,
    input  logic [IQ_SIZE*FU_W-1:0]     entry_fu,
    input  logic [NUM_FU-1:0]           fu_avail,
    output logic [ISSUE_PORTS-1:0]      issue_valid,
    input  logic [ISSUE_PORTS-1:0]      issue_ready,
    output logic [ISSUE_PORTS*IW-1:0]   issue_idx,
    output logic [ISSUE_PORTS*FU_W-1:0] issue_fu,
    output logic [ISSUE_PORTS-1:0]      issue_fire
);
    logic [ISSUE_PORTS-1:0]           r_valid;
    logic [ISSUE_PORTS-1:0][IW-1:0]   r_idx;
    logic [ISSUE_PORTS-1:0][FU_W-1:0] r_fu;
    logic [IW-1:0]                    r_ptr;

    logic [ISSUE_PORTS-1:0]           w_held;
    logic [ISSUE_PORTS-1:0]           w_fill;
    logic [ISSUE_PORTS-1:0][IW-1:0]   w_pick;
    logic [ISSUE_PORTS-1:0][FU_W-1:0] w_pick_fu;
    logic [NUM_FU-1:0]                w_blk;
    logic [IQ_SIZE-1:0]               w_base;
    logic [FU_W-1:0]                  w_efu [IQ_SIZE];
    logic [IW-1:0]                    w_ptr_nxt;

    assign issue_fire  = rst ? (r_valid & issue_ready & {ISSUE_PORTS{~flush}}) : '0;
    assign w_held      = r_valid & ~issue_fire;
    assign issue_valid = r_valid;
    assign issue_idx   = r_idx;
    assign issue_fu    = r_fu;

    for (genvar i = 0; i < IQ_SIZE; i++) begin : g_efu
        assign w_efu[i] = entry_fu[FU_W*i +: FU_W];
    end

    // Held grants own their FU and their entry until they fire.
    always_comb begin
        w_blk = '0;
        for (int p = 0; p < ISSUE_PORTS; p++)
            if (w_held[p]) w_blk[r_fu[p]] = 1'b1;
        for (int i = 0; i < IQ_SIZE; i++) begin
            w_base[i] = entry_valid[i] & entry_ready[i] & fu_avail[w_efu[i]] & ~w_blk[w_efu[i]];
            for (int p = 0; p < ISSUE_PORTS; p++)
                if (w_held[p] && r_idx[p] == IW'(i)) w_base[i] = 1'b0;
        end
    end

    // Each port sees the previous port's mask minus the FU it just took.
    for (genvar p = 0; p < ISSUE_PORTS; p++) begin : g_port
        logic [IQ_SIZE-1:0] w_m;
        logic               w_f;
        logic               w_new;
        logic [IW-1:0]      w_i;
        logic [FU_W-1:0]    w_fu;
        if (p == 0) begin : g_head
            assign w_m = w_base;
        end else begin : g_tail
            assign w_m = g_port[p-1].w_m & ~g_port[p-1].g_nx.w_x;
        end
        iq_issue_arbiter_rr_pick #(.N(IQ_SIZE), .W(IW)) u_rr_pick (
            .i_mask  (w_m),
            .i_start (r_ptr),
            .o_found (w_f),
            .o_idx   (w_i)
        );
        assign w_fu         = w_efu[w_i];
        assign w_new        = ~w_held[p] & w_f & ~stall_in;
        assign w_fill[p]    = w_new;
        assign w_pick[p]    = w_i;
        assign w_pick_fu[p] = w_fu;
        if (p + 1 < ISSUE_PORTS) begin : g_nx
            logic [IQ_SIZE-1:0] w_x;
            for (genvar i = 0; i < IQ_SIZE; i++) begin : g_x
                assign w_x[i] = w_new & (w_efu[i] == w_fu);
            end
        end
    end

    // Later ports pick further along the circle, so the last fill sets the pointer.
    always_comb begin
        w_ptr_nxt = r_ptr;
        for (int p = 0; p < ISSUE_PORTS; p++)
            if (w_fill[p]) w_ptr_nxt = (w_pick[p] == IW'(IQ_SIZE - 1)) ? '0 : w_pick[p] + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            r_idx   <= '0;
            r_fu    <= '0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else begin
            for (int p = 0; p < ISSUE_PORTS; p++) begin
                if (!w_held[p]) begin
                    r_valid[p] <= w_fill[p];
                    if (w_fill[p]) begin
                        r_idx[p] <= w_pick[p];
                        r_fu[p]  <= w_pick_fu[p];
                    end
                end
            end
            r_ptr <= w_ptr_nxt;
        end
    end
endmodule

// File: tb/tb_iq_issue_arbiter.sv
// tb_iq_issue_arbiter: directed checks of grant selection, hold, stall, flush and reset
module tb_iq_issue_arbiter;
    import iq_issue_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_in = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] entry_valid = '0;
    logic [15:0] entry_ready = '0;
    logic [31:0] entry_fu = '0;
    logic [3:0]  fu_avail = 4'hF;
    logic [1:0]  issue_ready = 2'b11;
    logic [1:0]  issue_valid;
    logic [7:0]  issue_idx;
    logic [3:0]  issue_fu;
    logic [1:0]  issue_fire;
    int          vecs = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    iq_issue_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .stall_in    (stall_in),
        .flush       (flush),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_fu    (entry_fu),
        .fu_avail    (fu_avail),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_idx   (issue_idx),
        .issue_fu    (issue_fu),
        .issue_fire  (issue_fire)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [1:0] f);
        entry_valid[i] = 1'b1;
        entry_ready[i] = 1'b1;
        entry_fu[2*i +: 2] = f;
    endtask

    task automatic drop(input int i);
        entry_valid[i] = 1'b0;
        entry_ready[i] = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_valid", issue_valid, 0);
        chk("rst_idx", issue_idx, 0);
        chk("rst_fu", issue_fu, 0);
        chk("rst_fire", issue_fire, 0);
        chk("rst_ptr", dut.r_ptr, 0);
        #10;
        // V1: two FUs, both ports fill and fire
        rst = 1'b1;
        put(3, FU_ALU);
        put(5, FU_LSU);
        tick();
        chk("v1_valid", issue_valid, 2'b11);
        chk("v1_idx", issue_idx, 8'h53);
        chk("v1_fu", issue_fu, 4'h4);
        chk("v1_fire", issue_fire, 2'b11);
        chk("v1_ptr", dut.r_ptr, 6);
        drop(3);
        drop(5);
        tick();
        chk("v1_idle", issue_valid, 2'b00);
        chk("v1_idle_ptr", dut.r_ptr, 6);
        // V2: same FU competes, second waits for the first to fire
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("v2_ptr0", dut.r_ptr, 0);
        put(2, FU_ALU);
        put(4, FU_ALU);
        tick();
        chk("v2_valid_a", issue_valid, 2'b01);
        chk("v2_idx_a", issue_idx[3:0], 2);
        chk("v2_ptr_a", dut.r_ptr, 3);
        drop(2);
        tick();
        chk("v2_valid_b", issue_valid, 2'b01);
        chk("v2_idx_b", issue_idx[3:0], 4);
        chk("v2_ptr_b", dut.r_ptr, 5);
        // V3: pointer wrap from 14
        drop(4);
        put(13, FU_MUL);
        tick();
        chk("v3_pre_idx", issue_idx[3:0], 13);
        chk("v3_pre_ptr", dut.r_ptr, 14);
        drop(13);
        put(1, FU_ALU);
        put(15, FU_LSU);
        tick();
        chk("v3_valid", issue_valid, 2'b11);
        chk("v3_idx", issue_idx, 8'h1F);
        chk("v3_fu", issue_fu, 4'h1);
        chk("v3_ptr", dut.r_ptr, 2);
        drop(1);
        drop(15);
        tick();
        chk("v3_idle", issue_valid, 2'b00);
        // V4: port0 held while its FU is back-pressured
        put(7, FU_BR);
        issue_ready = 2'b10;
        tick();
        chk("v4_grant_idx", issue_idx[3:0], 7);
        chk("v4_grant_ptr", dut.r_ptr, 8);
        for (int c = 0; c < 3; c++) begin
            fu_avail = c[0] ? 4'hF : 4'h7;
            tick();
            chk("v4_hold_valid", issue_valid, 2'b01);
            chk("v4_hold_idx", issue_idx[3:0], 7);
            chk("v4_hold_fu", issue_fu[1:0], 3);
            chk("v4_hold_fire", issue_fire, 2'b00);
        end
        issue_ready = 2'b11;
        fu_avail = 4'hF;
        drop(7);
        #1;
        chk("v4_fire", issue_fire, 2'b01);
        tick();
        chk("v4_idle", issue_valid, 2'b00);
        // V5: stall blocks grants and holds the pointer
        stall_in = 1'b1;
        put(0, FU_ALU);
        put(1, FU_LSU);
        put(10, FU_MUL);
        put(12, FU_BR);
        tick();
        chk("v5_stall_valid", issue_valid, 2'b00);
        chk("v5_stall_ptr", dut.r_ptr, 8);
        tick();
        chk("v5_stall_valid2", issue_valid, 2'b00);
        stall_in = 1'b0;
        tick();
        chk("v5_resume_valid", issue_valid, 2'b11);
        chk("v5_resume_idx", issue_idx, 8'hCA);
        chk("v5_resume_fu", issue_fu, 4'hE);
        chk("v5_resume_ptr", dut.r_ptr, 13);
        stall_in = 1'b1;
        issue_ready = 2'b01;
        drop(10);
        #1;
        chk("v5_stall_fire", issue_fire, 2'b01);
        tick();
        chk("v5_partial_valid", issue_valid, 2'b10);
        chk("v5_partial_idx", issue_idx[7:4], 12);
        chk("v5_partial_ptr", dut.r_ptr, 13);
        stall_in = 1'b0;
        issue_ready = 2'b11;
        drop(12);
        tick();
        chk("v5_wrap_valid", issue_valid, 2'b11);
        chk("v5_wrap_idx", issue_idx, 8'h10);
        chk("v5_wrap_fu", issue_fu, 4'h4);
        chk("v5_wrap_ptr", dut.r_ptr, 2);
        // V6: flush suppresses fire, then async reset mid-grant
        flush = 1'b1;
        #1;
        chk("v6_flush_fire", issue_fire, 2'b00);
        tick();
        flush = 1'b0;
        chk("v6_flush_valid", issue_valid, 2'b00);
        chk("v6_flush_ptr", dut.r_ptr, 0);
        tick();
        chk("v6_regrant_valid", issue_valid, 2'b11);
        chk("v6_regrant_fire", issue_fire, 2'b11);
        chk("v6_regrant_ptr", dut.r_ptr, 2);
        #2;
        rst = 1'b0;
        #1;
        chk("v6_rst_valid", issue_valid, 2'b00);
        chk("v6_rst_idx", issue_idx, 0);
        chk("v6_rst_fu", issue_fu, 0);
        chk("v6_rst_fire", issue_fire, 2'b00);
        chk("v6_rst_ptr", dut.r_ptr, 0);
        drop(0);
        drop(1);
        #3;
        rst = 1'b1;
        tick();
        chk("v6_post_valid", issue_valid, 2'b00);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
